// File: rtl/axi_interconnect_pkg.sv
// Shared definitions for the AXI crossbar write scheduler: FSM encoding and
// the index-width helper.
package axi_interconnect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } wr_state_e;

    // ceil(log2(n)), never below 1 so a 1-bit index exists even for tiny NUM
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/axi_interconnect_crossbar_arbit_polling.sv
// Combinational round-robin picker: first requester at or after last_user-1,
// wrapping modulo NUM.
module axi_interconnect_crossbar_arbit_polling #(
    parameter int NUM   = 4,
    parameter int WIDTH = 2
) (
    input  logic [NUM-1:0]   req,
    input  logic [WIDTH-1:0] last_user,
    output logic [WIDTH-1:0] current_user
);

    logic [WIDTH-1:0] start;
    logic             found;

    always_comb begin
        start        = last_user - WIDTH'(1);
        current_user = '0;
        found        = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            if (!found && req[(int'(start) + i) % NUM]) begin
                current_user = WIDTH'((int'(start) + i) % NUM);
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_interconnect_crossbar_wr_sched.sv
// Per-slave-port write scheduler: one master owns AW, the whole W burst and B
// before the next round-robin arbitration.
module axi_interconnect_crossbar_wr_sched
    import axi_interconnect_pkg::*;
#(
    parameter int NUM   = 4,
    parameter int WIDTH = clog2_min1(NUM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NUM-1:0]   m_awvalid,
    output logic [NUM-1:0]   m_awready,
    output logic             s_awvalid,
    input  logic             s_awready,
    input  logic [NUM-1:0]   m_wvalid,
    input  logic [NUM-1:0]   m_wlast,
    output logic [NUM-1:0]   m_wready,
    output logic             s_wvalid,
    output logic             s_wlast,
    input  logic             s_wready,
    input  logic             s_bvalid,
    output logic             s_bready,
    output logic [NUM-1:0]   m_bvalid,
    input  logic [NUM-1:0]   m_bready,
    output logic             grant_valid,
    output logic [WIDTH-1:0] grant_id,
    output logic [7:0]       wbeat_cnt
);

    wr_state_e        state_q, state_d;
    logic [WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] grant_id_d;
    logic             grant_valid_d;
    logic [7:0]       wbeat_d;
    logic [WIDTH-1:0] last_user;
    logic [WIDTH-1:0] pick;

    // The picker starts at last_user-1, so feed it rr_ptr+1 to start at rr_ptr.
    assign last_user = rr_ptr_q + WIDTH'(1);

    axi_interconnect_crossbar_arbit_polling #(
        .NUM   (NUM),
        .WIDTH (WIDTH)
    ) u_arbit (
        .req          (m_awvalid),
        .last_user    (last_user),
        .current_user (pick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            wbeat_cnt   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id    <= grant_id_d;
            grant_valid <= grant_valid_d;
            wbeat_cnt   <= wbeat_d;
        end
    end

    // Handshake: a transfer happens on a cycle where valid and ready are both
    // high; only the granted master's bits are forwarded, all others stay 0.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id;
        grant_valid_d = grant_valid;
        wbeat_d       = wbeat_cnt;
        m_awready     = '0;
        m_wready      = '0;
        m_bvalid      = '0;
        s_awvalid     = 1'b0;
        s_wvalid      = 1'b0;
        s_wlast       = 1'b0;
        s_bready      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|m_awvalid) begin
                    state_d       = ST_AW;
                    grant_id_d    = pick;
                    grant_valid_d = 1'b1;
                end
            end
            ST_AW: begin
                s_awvalid           = m_awvalid[grant_id];
                m_awready[grant_id] = s_awready;
                if (s_awvalid && s_awready) begin
                    state_d = ST_W;
                    wbeat_d = '0;
                end
            end
            ST_W: begin
                s_wvalid           = m_wvalid[grant_id];
                s_wlast            = m_wlast[grant_id];
                m_wready[grant_id] = s_wready;
                if (s_wvalid && s_wready) begin
                    if (wbeat_cnt != 8'hFF) wbeat_d = wbeat_cnt + 8'd1;
                    if (s_wlast) state_d = ST_B;
                end
            end
            ST_B: begin
                m_bvalid[grant_id] = s_bvalid;
                s_bready           = m_bready[grant_id];
                if (s_bvalid && s_bready) begin
                    state_d       = ST_IDLE;
                    grant_valid_d = 1'b0;
                    rr_ptr_d      = (grant_id == WIDTH'(NUM - 1)) ? '0 : grant_id + WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_interconnect_crossbar_wr_sched.sv
// Directed bench for the write scheduler: per-cycle vector table plus
// hand-written sequences for stalls, early W data and async reset.
module tb_axi_interconnect_crossbar_wr_sched;

    localparam int NUM   = 4;
    localparam int WIDTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NUM-1:0]   m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
    logic             s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
    logic             grant_valid;
    logic [WIDTH-1:0] grant_id;
    logic [7:0]       wbeat_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        rst;
        logic [3:0]  awv, wv, wl, bry;
        logic        s_awr, s_wr, s_bv;
        logic [26:0] exp;
    } vec_t;

    vec_t vecs[$];

    axi_interconnect_crossbar_wr_sched #(.NUM(NUM), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_awvalid   (m_awvalid),
        .m_awready   (m_awready),
        .s_awvalid   (s_awvalid),
        .s_awready   (s_awready),
        .m_wvalid    (m_wvalid),
        .m_wlast     (m_wlast),
        .m_wready    (m_wready),
        .s_wvalid    (s_wvalid),
        .s_wlast     (s_wlast),
        .s_wready    (s_wready),
        .s_bvalid    (s_bvalid),
        .s_bready    (s_bready),
        .m_bvalid    (m_bvalid),
        .m_bready    (m_bready),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .wbeat_cnt   (wbeat_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [26:0] pack_out();
        return {grant_valid, grant_id, s_awvalid, s_wvalid, s_wlast, s_bready,
                m_awready, m_wready, m_bvalid, wbeat_cnt};
    endfunction

    function automatic logic [26:0] mk(input logic gv, input logic [1:0] gid,
                                       input logic saw, input logic sw, input logic swl,
                                       input logic sbr, input logic [3:0] mawr,
                                       input logic [3:0] mwr, input logic [3:0] mbv,
                                       input logic [7:0] cnt);
        return {gv, gid, saw, sw, swl, sbr, mawr, mwr, mbv, cnt};
    endfunction

    // scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive_zero();
        m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        drive_zero();
        step();
        rst_n = 1'b1;
    endtask

    task automatic add(input logic rst, input logic [3:0] awv, input logic [3:0] wv,
                       input logic [3:0] wl, input logic [3:0] bry, input logic s_awr,
                       input logic s_wr, input logic s_bv, input logic [26:0] exp);
        vec_t v;
        v.rst = rst; v.awv = awv; v.wv = wv; v.wl = wl; v.bry = bry;
        v.s_awr = s_awr; v.s_wr = s_wr; v.s_bv = s_bv; v.exp = exp;
        vecs.push_back(v);
    endtask

    // 1-beat write with everything ready: IDLE, AW, W, B rows
    task automatic add_txn(input logic [3:0] req, input logic [1:0] g,
                           input logic [1:0] prev, input logic [7:0] idle_cnt);
        logic [3:0] oh;
        oh = 4'(1 << g);
        add(0, req, req, req, req, 1, 1, 1, mk(0, prev, 0, 0, 0, 0, 0, 0, 0, idle_cnt));
        add(0, req, req, req, req, 1, 1, 1, mk(1, g, 1, 0, 0, 0, oh, 0, 0, idle_cnt));
        add(0, req, req, req, req, 1, 1, 1, mk(1, g, 0, 1, 1, 0, 0, oh, 0, 8'd0));
        add(0, req, req, req, req, 1, 1, 1, mk(1, g, 0, 0, 0, 1, 0, 0, oh, 8'd1));
    endtask

    task automatic add_reset_row();
        add(1, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        rst_n = 1'b0;
        drive_zero();

        // master 2 alone, 4-beat burst, slave always ready
        add(0, 4'b0100, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 4'b0100, 0, 0, 0, 1, 0, 0, mk(1, 2, 1, 0, 0, 0, 4'b0100, 0, 0, 0));
        add(0, 0, 4'b0100, 0, 0, 0, 1, 0, mk(1, 2, 0, 1, 0, 0, 0, 4'b0100, 0, 0));
        add(0, 0, 4'b0100, 0, 0, 0, 1, 0, mk(1, 2, 0, 1, 0, 0, 0, 4'b0100, 0, 1));
        add(0, 0, 4'b0100, 0, 0, 0, 1, 0, mk(1, 2, 0, 1, 0, 0, 0, 4'b0100, 0, 2));
        add(0, 0, 4'b0100, 4'b0100, 0, 0, 1, 0, mk(1, 2, 0, 1, 1, 0, 0, 4'b0100, 0, 3));
        add(0, 0, 0, 0, 4'b0100, 0, 0, 1, mk(1, 2, 0, 0, 0, 1, 0, 0, 4'b0100, 4));
        add(0, 0, 0, 0, 0, 0, 0, 0, mk(0, 2, 0, 0, 0, 0, 0, 0, 0, 4));
        // all four request continuously: 0,1,2,3,0
        add_reset_row();
        add_txn(4'b1111, 0, 0, 0);
        add_txn(4'b1111, 1, 0, 1);
        add_txn(4'b1111, 2, 1, 1);
        add_txn(4'b1111, 3, 2, 1);
        add_txn(4'b1111, 0, 3, 1);
        // master 1, then {0,3} twice: 3 then 0
        add_reset_row();
        add_txn(4'b0010, 1, 0, 0);
        add_txn(4'b1001, 3, 1, 1);
        add_txn(4'b1001, 0, 3, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'(pack_out()), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step();
            rst_n     = !vecs[i].rst;
            m_awvalid = vecs[i].awv;
            m_wvalid  = vecs[i].wv;
            m_wlast   = vecs[i].wl;
            m_bready  = vecs[i].bry;
            s_awready = vecs[i].s_awr;
            s_wready  = vecs[i].s_wr;
            s_bvalid  = vecs[i].s_bv;
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'(pack_out()), 32'(vecs[i].exp));
        end

        // s_wready toggling on a 3-beat burst, wlast held while stalled
        do_reset();
        m_awvalid = 4'b0001;
        step();
        s_awready = 1'b1;
        step();
        m_awvalid = '0; s_awready = 1'b0; m_wvalid = 4'b0001; s_wready = 1'b1;
        @(negedge clk);
        check("t5_beat1_wready", 32'(m_wready), 32'h1);
        step();
        s_wready = 1'b0;
        @(negedge clk);
        check("t5_cnt_after_b1", 32'(wbeat_cnt), 32'd1);
        step();
        s_wready = 1'b1;
        step();
        s_wready = 1'b0; m_wlast = 4'b0001; s_bvalid = 1'b1;
        @(negedge clk);
        check("t5_wlast_stalled", 32'({s_wlast, wbeat_cnt}), 32'({1'b1, 8'd2}));
        step();
        @(negedge clk);
        check("t5_still_in_w", 32'({grant_valid, s_wvalid, m_bvalid, wbeat_cnt}),
              32'({1'b1, 1'b1, 4'b0000, 8'd2}));
        step();
        s_wready = 1'b1;
        @(negedge clk);
        check("t5_last_beat", 32'(m_wready), 32'h1);
        step();
        s_wready = 1'b0; m_wvalid = '0; m_wlast = '0; m_bready = 4'b0001;
        @(negedge clk);
        check("t5_in_b", 32'({m_bvalid, s_bready, wbeat_cnt}), 32'({4'b0001, 1'b1, 8'd3}));
        step();
        drive_zero();
        @(negedge clk);
        check("t5_back_idle", 32'(grant_valid), 32'd0);

        // W data before AW, and awvalid dropped while in AW
        do_reset();
        m_wvalid = 4'b0001; m_wlast = 4'b0001; s_wready = 1'b1;
        @(negedge clk);
        check("t6_early_w_idle", 32'({m_wready, s_wvalid}), 32'd0);
        step();
        m_awvalid = 4'b0001;
        @(negedge clk);
        check("t6_early_w_req", 32'(m_wready), 32'd0);
        step();
        m_awvalid = '0;
        @(negedge clk);
        check("t6_aw_dropped", 32'({grant_valid, grant_id, s_awvalid, m_wready}),
              32'({1'b1, 2'd0, 1'b0, 4'b0000}));
        step();
        m_awvalid = 4'b0001;
        @(negedge clk);
        check("t6_aw_not_ready", 32'({s_awvalid, m_awready, m_wready}), 32'({1'b1, 8'h00}));
        step();
        s_awready = 1'b1;
        @(negedge clk);
        check("t6_aw_hs", 32'({m_awready, m_wready}), 32'({4'b0001, 4'b0000}));
        step();
        m_awvalid = '0; s_awready = 1'b0;
        @(negedge clk);
        check("t6_w_flows", 32'({m_wready, s_wvalid, s_wlast}), 32'({4'b0001, 1'b1, 1'b1}));
        step();
        m_wvalid = '0; m_wlast = '0; s_bvalid = 1'b1; m_bready = 4'b0001;
        @(negedge clk);
        check("t6_b", 32'({m_bvalid, wbeat_cnt}), 32'({4'b0001, 8'd1}));
        step();
        drive_zero();
        @(negedge clk);
        check("t6_idle", 32'(grant_valid), 32'd0);

        // asynchronous reset in the middle of a burst
        step();
        m_awvalid = 4'b1000; s_awready = 1'b1; m_wvalid = 4'b1000; s_wready = 1'b1;
        step();
        step();
        @(negedge clk);
        check("t1_pre_reset", 32'({grant_valid, grant_id, m_wready}), 32'({1'b1, 2'd3, 4'b1000}));
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_async_reset", 32'(pack_out()), 32'd0);
        step();
        rst_n = 1'b1;
        drive_zero();
        @(negedge clk);
        check("t1_after_reset", 32'(pack_out()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
